// File: rtl/uart_wide_rx.sv
// Oversampling receiver for the 128-bit wide-frame serial link: start, DATA_BITS data LSB first,
// odd parity, stop. Define UART_WIDE_RX_ERRCNT_EN to add the saturating error counter (err_count/err_clr).
module uart_wide_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err
`ifdef UART_WIDE_RX_ERRCNT_EN
  ,
  input  logic                 err_clr,
  output logic [7:0]           err_count
`endif
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_s, rx_prev;
  logic [CW-1:0]          sample_cnt;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   acc, perr;
  logic                   sample, start_ok, shift_en, perr_ld, good_set, pe_set, fe_set;

  // Line idles high, so the synchronizer and edge detector reset to 1 to avoid a phantom start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign sample = (sample_cnt == MID);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    start_ok  = 1'b0;
    shift_en  = 1'b0;
    perr_ld   = 1'b0;
    good_set  = 1'b0;
    pe_set    = 1'b0;
    fe_set    = 1'b0;
    case (state)
      IDLE:   if (rx_prev && !rx_s) state_nxt = START;
      START:  if (sample) begin
                if (!rx_s) begin
                  state_nxt = DATA;
                  start_ok  = 1'b1;
                end else begin
                  state_nxt = IDLE;
                end
              end
      DATA:   if (sample) begin
                shift_en = 1'b1;
                if (bit_idx == LAST_BIT) state_nxt = PARITY;
              end
      PARITY: if (sample) begin
                perr_ld   = 1'b1;
                state_nxt = STOP;
              end
      STOP:   if (sample) begin
                if (!rx_s) begin
                  fe_set    = 1'b1;
                  state_nxt = BREAK;
                end else if (perr) begin
                  pe_set    = 1'b1;
                  state_nxt = IDLE;
                end else begin
                  good_set  = 1'b1;
                  state_nxt = IDLE;
                end
              end
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counter wraps at OVERSAMPLE-1, so mid-bit repeats every OVERSAMPLE clocks for any even ratio.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      sample_cnt <= '0;
      bit_idx    <= '0;
      acc        <= 1'b1;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == IDLE || state == BREAK) sample_cnt <= '0;
      else if (sample_cnt == LAST_CNT)     sample_cnt <= '0;
      else                                 sample_cnt <= sample_cnt + CW'(1);

      if (start_ok)      bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + BW'(1);

      if (start_ok)      acc <= 1'b1;
      else if (shift_en) acc <= acc ^ rx_s;

      if (perr_ld) perr <= (rx_s != acc);

      rx_valid   <= good_set;
      parity_err <= pe_set;
      frame_err  <= fe_set;
      if (good_set) rx_data <= shreg;

      if (start_ok)      rx_done <= 1'b0;
      else if (good_set) rx_done <= 1'b1;
    end
  end

  // NOTE: the shift register needs no reset; all DATA_BITS are overwritten before it is ever copied out.
  always_ff @(posedge clock) begin
    if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
  end

`ifdef UART_WIDE_RX_ERRCNT_EN
  always_ff @(posedge clock) begin
    if (reset || err_clr)                       err_count <= 8'h00;
    else if ((pe_set || fe_set) && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_uart_wide_rx.sv
// Self-checking bench for uart_wide_rx: directed and random frames checked against a frame-level
// outcome model (parity by population count, stop/parity priority, last-good payload tracking).
module tb_uart_wide_rx;
  localparam int OS = 16;
  localparam int DB = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          UART_RX;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_done, parity_err, frame_err;
`ifdef UART_WIDE_RX_ERRCNT_EN
  logic          err_clr;
  logic [7:0]    err_count;
`endif

  always #5 clock = ~clock;

  uart_wide_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clock      (clock),
    .reset      (reset),
    .UART_RX    (UART_RX),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_done    (rx_done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
`ifdef UART_WIDE_RX_ERRCNT_EN
    ,
    .err_clr    (err_clr),
    .err_count  (err_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pulse monitor: sole writer of these counters; the stimulus side only takes snapshots.
  int            n_valid = 0, n_perr = 0, n_ferr = 0;
  logic [DB-1:0] cap_data = '0;
  always @(negedge clock) begin
    if (rx_valid) begin
      n_valid  = n_valid + 1;
      cap_data = rx_data;
    end
    if (parity_err) n_perr = n_perr + 1;
    if (frame_err)  n_ferr = n_ferr + 1;
  end

  // Reference model state
  logic [DB-1:0] m_data;
  logic          m_done;
  int            m_errs;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [DB-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic odd_par(input logic [DB-1:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop,
                            input int low_after);
    logic [DB+2:0] fr;
    int v0, p0, f0;
    logic ev, ep, ef;
    fr = {stop, par, d, 1'b0};
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    ev = 1'b0; ep = 1'b0; ef = 1'b0;
    if (!stop)                  ef = 1'b1;
    else if (par != odd_par(d)) ep = 1'b1;
    else                        ev = 1'b1;
    m_done = 1'b0;

    UART_RX = 1'b0;
    tick(OS - 1);
    @(negedge clock);
    check("done_fall_at_start", rx_done, 0);
    @(posedge clock); #1;
    for (int i = 1; i <= DB + 1; i++) begin
      UART_RX = fr[i];
      tick(OS);
    end
    UART_RX = stop;
    if (ev) begin
      m_data = d;
      m_done = 1'b1;
    end
    if ((ep || ef) && m_errs < 255) m_errs++;
    repeat (11) @(posedge clock);
    @(negedge clock);
    check("done_at_stop", rx_done, m_done);
    repeat (5) @(posedge clock);
    #1;
    if (!stop) begin
      tick(low_after);
      UART_RX = 1'b1;
      tick(OS);
    end
    check("valid_pulses", n_valid - v0, ev ? 1 : 0);
    check("parity_pulses", n_perr - p0, ep ? 1 : 0);
    check("frame_pulses", n_ferr - f0, ef ? 1 : 0);
    check("rx_data", rx_data, m_data);
    if (ev) check("captured_data", cap_data, d);
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    tick(n);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic [DB+2:0] fr;
    logic          par, stop;
    int            v0, p0, f0;

    reset   = 1'b1;
    UART_RX = 1'b1;
`ifdef UART_WIDE_RX_ERRCNT_EN
    err_clr = 1'b0;
`endif
    m_data = '0; m_done = 1'b0; m_errs = 0;
    tick(3);
    @(negedge clock);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_done", rx_done, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(OS);

    // All-zero payload, then back-to-back frames with no idle gap
    send_frame('0, 1'b1, 1'b1, 0);
    idle(20);
    d = '0; d[DB-1] = 1'b1; d[0] = 1'b1;
    send_frame(d, 1'b1, 1'b1, 0);
    send_frame(128'h1, 1'b0, 1'b1, 0);
    idle(30);
    check("done_held_idle", rx_done, 1);

    // Wrong parity, then resend with correct parity
    send_frame(128'h1, 1'b1, 1'b1, 0);
    idle(10);
    send_frame(128'h1, 1'b0, 1'b1, 0);
    idle(10);

    // Stop bit low, line held low 40 clocks, then a good frame
    d = rand_word();
    send_frame(d, odd_par(d), 1'b0, 40);
    d = rand_word();
    send_frame(d, odd_par(d), 1'b1, 0);
    idle(10);

    // Three-clock glitch is a false start
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    UART_RX = 1'b0;
    tick(3);
    idle(40);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_errs", (n_perr - p0) + (n_ferr - f0), 0);
    check("glitch_done", rx_done, m_done);

    // Random frames with random gaps, bad parity and the occasional framing error
    for (int k = 0; k < 8; k++) begin
      d    = rand_word();
      par  = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, par, stop, $urandom_range(0, 30));
      idle($urandom_range(0, 20));
    end
    d = rand_word();
    send_frame(d, odd_par(d), 1'b1, 0);
    idle(5);

    // Reset in the middle of data bit 64
    d  = rand_word();
    fr = {1'b1, odd_par(d), d, 1'b0};
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    for (int i = 0; i <= 64; i++) begin
      UART_RX = fr[i];
      tick(OS);
    end
    UART_RX = fr[65];
    tick(8);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_done", rx_done, 0);
    check("midrst_errs", {parity_err, frame_err}, 0);
    @(posedge clock); #1;
    reset   = 1'b0;
    UART_RX = 1'b1;
    m_data = '0; m_done = 1'b0; m_errs = 0;
    tick(2 * OS);
    check("midrst_no_pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
    d = rand_word();
    send_frame(d, odd_par(d), 1'b1, 0);
    idle(10);

`ifdef UART_WIDE_RX_ERRCNT_EN
    for (int k = 0; k < 3; k++) begin
      d = rand_word();
      send_frame(d, ~odd_par(d), 1'b1, 0);
      idle(5);
    end
    check("err_count", err_count, m_errs);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    @(negedge clock);
    check("err_count_clr", err_count, 0);
    @(posedge clock); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
